// File: rtl/imm_encoder.sv
// imm_encoder
//   Two-stage valid/ready pipeline that packs register fields and a 32-bit
//   immediate into a RISC-V I/S/B/U instruction word.
//   Stage 1 latches the request and range-checks the immediate for its format.
//   Stage 2 holds the packed word (or 0 with out_err set when the check failed).
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     in_valid/in_ready           request handshake
//     in_fmt                      00 I, 01 S, 10 B, 11 U
//     in_opcode/rd/rs1/rs2/funct3 instruction fields
//     in_imm                      two's complement immediate
//     out_valid/out_ready         result handshake
//     out_instr, out_err          encoded word / range error flag
//     cnt_ok, cnt_err             saturating delivered-word counters
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_U = 2'b11;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } req_t;

  req_t             r_s1;
  logic             r_s1_vld;
  logic             r_s1_ok;
  logic             r_s2_vld;
  logic [31:0]      r_s2_instr;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_cnt_ok;
  logic [CNT_W-1:0] r_cnt_err;

  logic             w_out_fire;
  logic             w_s2_load;
  logic             w_in_fire;
  logic             w_ok;
  logic [31:0]      w_pack;
  req_t             w_req;

  assign w_out_fire = r_s2_vld && out_ready;
  // s1 advances whenever s2 is empty or is being drained this edge
  assign w_s2_load  = r_s1_vld && (!r_s2_vld || out_ready);
  assign in_ready   = !r_s1_vld || w_s2_load;
  assign w_in_fire  = in_valid && in_ready;

  assign w_req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                   rs2: in_rs2, funct3: in_funct3, imm: in_imm};

  // Range check: upper bits must be a pure sign extension of the field
  always_comb begin
    w_ok = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: w_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
      FMT_B:        w_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
      FMT_U:        w_ok = !(|in_imm[11:0]);
      default:      w_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_pack = 32'h0;
    case (r_s1.fmt)
      FMT_I: w_pack = {r_s1.imm[11:0], r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
      FMT_S: w_pack = {r_s1.imm[11:5], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                       r_s1.imm[4:0], r_s1.opcode};
      FMT_B: w_pack = {r_s1.imm[12], r_s1.imm[10:5], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                       r_s1.imm[4:1], r_s1.imm[11], r_s1.opcode};
      FMT_U: w_pack = {r_s1.imm[31:12], r_s1.rd, r_s1.opcode};
      default: w_pack = 32'h0;
    endcase
  end

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
      r_s1_ok  <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_vld <= 1'b1;
      r_s1     <= w_req;
      r_s1_ok  <= w_ok;
    end else if (w_s2_load) begin
      r_s1_vld <= 1'b0;
    end
  end

  // Stage 2 (output register); held stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld   <= 1'b0;
      r_s2_instr <= 32'h0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_vld   <= 1'b1;
      r_s2_instr <= r_s1_ok ? w_pack : 32'h0;
      r_s2_err   <= !r_s1_ok;
    end else if (w_out_fire) begin
      r_s2_vld   <= 1'b0;
    end
  end

  // Saturating delivered-word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
    end else if (w_out_fire) begin
      if (!r_s2_err) begin
        if (!(&r_cnt_ok)) r_cnt_ok <= r_cnt_ok + 1'b1;
      end else begin
        if (!(&r_cnt_err)) r_cnt_err <= r_cnt_err + 1'b1;
      end
    end
  end

  assign out_valid = r_s2_vld;
  assign out_instr = r_s2_instr;
  assign out_err   = r_s2_err;
  assign cnt_ok    = r_cnt_ok;
  assign cnt_err   = r_cnt_err;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_fmt = '0;
  logic [6:0]       in_opcode = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_ok = 0;
  int   m_err = 0;
  int   pops = 0;
  logic last_acc;
  logic [31:0] last_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference encoder: range rules as signed intervals / alignment, fields by shifts
  function automatic exp_t ref_enc(input logic [1:0] f, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [31:0] imm);
    exp_t e;
    int   s;
    bit   ok;
    logic [31:0] w;
    s = int'(imm);
    ok = 1'b0;
    w = 32'(op) | (32'(rs1) << 15) | (32'(f3) << 12);
    case (f)
      2'd0: begin
        ok = (s >= -2048) && (s <= 2047);
        w = w | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
      end
      2'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w = w | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
      end
      2'd2: begin
        ok = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
        w = w | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      end
      default: begin
        ok = (imm % 4096 == 0);
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
    endcase
    e.instr = ok ? w : 32'h0;
    e.err   = !ok;
    return e;
  endfunction

  task automatic drive(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [31:0] imm);
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
  endtask

  // One clock: handshakes sampled at the falling edge, then advance past posedge
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc)
      exp_q.push_back(ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm));
    if (out_valid && out_ready) begin
      pops++;
      last_out = out_instr;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(out_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_err", 32'(out_err), 32'(e.err));
        if (e.err) m_err++; else m_ok++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [31:0] imm);
    int n;
    drive(f, op, rd, rs1, rs2, f3, imm);
    n = 0;
    do begin cyc(); n++; end while (!last_acc && n < 50);
    if (!last_acc) chk("accept_timeout", 32'(last_acc), 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    exp_t ea;
    int sent, n, p0, base;
    logic [31:0] imm, hold;
    logic [1:0] f;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);
    chk("rst_cnt_ok", 32'(cnt_ok), 32'h0);
    chk("rst_cnt_err", 32'(cnt_err), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // I-type with latency check
    drive(2'b00, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF);
    cyc();
    chk("i_accept", 32'(last_acc), 32'h1);
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 32'h0);
    cyc();
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("i_instr", out_instr, 32'hFFF30293);
    chk("i_err", 32'(out_err), 32'h0);
    cyc();
    chk("i_cnt_ok", 32'(cnt_ok), 32'h1);

    send(2'b01, 7'h23, 5'd0, 5'd2, 5'd7, 3'd2, 32'd8);
    drain();
    chk("s_instr", last_out, 32'h00712423);
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC);
    drain();
    chk("b_instr", last_out, 32'hFE208EE3);
    send(2'b11, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345000);
    drain();
    chk("u_instr", last_out, 32'h12345537);

    // Range errors
    send(2'b00, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'h800);
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h1000);
    send(2'b11, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h12345001);
    drain();
    chk("err_last_instr", last_out, 32'h0);
    chk("err_cnt_err", 32'(cnt_err), 32'd4);
    chk("err_cnt_ok", 32'(cnt_ok), 32'd4);
    send(2'b00, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h7FF);
    send(2'b00, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFFF800);
    drain();
    chk("bnd_cnt_ok", 32'(cnt_ok), 32'd6);
    chk("bnd_cnt_err", 32'(cnt_err), 32'd4);

    // Backpressure: three back-to-back requests with out_ready low
    out_ready = 1'b0;
    ea = ref_enc(2'b00, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 32'd100);
    drive(2'b00, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 32'd100); cyc();
    chk("bp_acc0", 32'(last_acc), 32'h1);
    drive(2'b01, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFFFFF0); cyc();
    chk("bp_acc1", 32'(last_acc), 32'h1);
    drive(2'b11, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 32'hABCDE000); cyc();
    chk("bp_acc2_blocked", 32'(last_acc), 32'h0);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    chk("bp_out_instr", out_instr, ea.instr);
    hold = out_instr;
    cyc();
    chk("bp_stable", out_instr, hold);
    chk("bp_valid_held", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    p0 = pops;
    cyc();
    chk("bp_acc2", 32'(last_acc), 32'h1);
    in_valid = 1'b0;
    cyc(); cyc();
    chk("bp_pops", 32'(pops - p0), 32'd3);
    chk("bp_empty", 32'(exp_q.size()), 32'h0);
    chk("bp_cnt_ok", 32'(cnt_ok), 32'(m_ok));

    // Random streaming with random backpressure
    base = m_ok + m_err;
    sent = 0; n = 0;
    in_valid = 1'b0;
    while (sent < 100 && n < 5000) begin
      out_ready = $urandom_range(0, 1);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        f = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: imm = $urandom;
          1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          2: imm = $urandom & 32'hFFFFF000;
          default: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFFFFFE;
        endcase
        drive(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
      end
      cyc();
      n++;
      if (last_acc) begin sent++; in_valid = 1'b0; end
    end
    if (n >= 5000) chk("rand_timeout", 32'(sent), 32'd100);
    drain();
    chk("rand_sum", 32'(m_ok + m_err - base), 32'd100);
    chk("rand_cnt_ok", 32'(cnt_ok), 32'(m_ok));
    chk("rand_cnt_err", 32'(cnt_err), 32'(m_err));

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(2'b00, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1);
    send(2'b00, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 32'd2);
    chk("pre_rst_in_ready", 32'(in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    chk("mrst_out_instr", out_instr, 32'h0);
    chk("mrst_cnt_ok", 32'(cnt_ok), 32'h0);
    chk("mrst_cnt_err", 32'(cnt_err), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'h1);
    exp_q.delete();
    m_ok = 0; m_err = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    send(2'b00, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF);
    drain();
    chk("post_rst_instr", last_out, 32'hFFF30293);
    chk("post_rst_cnt_ok", 32'(cnt_ok), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Streaming RISC-V instruction encoder that packs register fields and a 32-bit immediate into a 32-bit instruction word for I, S, B and U formats. It performs the inverse of the decode-side immediate sign-extension and range-checks the immediate against the target format. The block sits in the test/self-modifying-code path as a source of instruction words for instruction memory or a stimulus generator. It is a two-stage valid/ready pipeline with full backpressure and saturating result counters.

## Interface

- CNT_W, 16, width of the ok/error counters
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input request valid
- in_ready  out  1  block can accept a request this cycle
- in_fmt  in  2  format: 00 I, 01 S, 10 B, 11 U
- in_opcode  in  7  instr[6:0]
- in_rd  in  5  destination register (I, U)
- in_rs1  in  5  source 1 (I, S, B)
- in_rs2  in  5  source 2 (S, B)
- in_funct3  in  3  instr[14:12] (I, S, B)
- in_imm  in  32  immediate value, two's complement
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_instr  out  32  encoded instruction; 0 when out_err
- out_err  out  1  immediate out of range for in_fmt
- cnt_ok  out  CNT_W  saturating count of delivered good words
- cnt_err  out  CNT_W  saturating count of delivered error words

## Operation

- Input handshake: request accepted when in_valid && in_ready. Output handshake: word consumed when out_valid && out_ready.
- Stage 1 (registered on accept): latch fields, compute range check.
  - I, S: ok iff in_imm[31:11] all equal (fits 12-bit signed).
  - B: ok iff in_imm[31:12] all equal and in_imm[0] == 0.
  - U: ok iff in_imm[11:0] == 0.
- Stage 2 (output register): pack word, or 32'h0 with out_err=1 if check failed.
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - Fields unused by the format are ignored.
- Stage advance: s2 loads from s1 when s2 empty or s2 consumed this cycle; s1 loads from input when s1 empty or s1 advancing. in_ready = !s1_valid || s1_advance (combinational from out_ready, no path from in_valid).
- Counters: on each output handshake, cnt_ok += 1 if !out_err else cnt_err += 1; hold at all-ones.
- Order preserved; no drop, no duplication.

## Timing

- Reset (async assert, sync deassert by clk): s1/s2 valid = 0, out_valid=0, out_instr=0, out_err=0, cnt_ok=0, cnt_err=0; in_ready=1 from reset.
- Latency: word accepted at edge N is presented at out_valid after edge N+1 (2-cycle accept-to-output).
- Throughput: 1 word/cycle with out_ready held high.
- Backpressure: with out_ready=0, at most 2 requests are held; in_ready deasserts once both stages are full. out_instr/out_err stable while out_valid && !out_ready.
- Simultaneous consume and accept with both stages full: s2 takes s1, s1 takes input in the same edge; in_ready=1 that cycle.
- Reset mid-operation: in-flight words discarded, counters cleared; no partial word emitted after deassert.

## Test plan

- I-type fmt=00 opcode=0x13 rd=5 rs1=6 f3=0 imm=0xFFFFFFFF -> out_instr=0xFFF30293, out_err=0, cnt_ok=1, out_valid exactly 2 cycles after accept.
- S-type fmt=01 opcode=0x23 rs1=2 rs2=7 f3=2 imm=8 -> 0x00712423; B-type fmt=10 opcode=0x63 rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3; U-type fmt=11 opcode=0x37 rd=10 imm=0x12345000 -> 0x12345537.
- Range errors: I imm=0x800, B imm=3, B imm=0x1000, U imm=0x12345001 -> each out_err=1, out_instr=0; cnt_err=4, cnt_ok unchanged; boundary I imm=0x7FF and 0xFFFFF800 -> ok.
- Backpressure: out_ready=0, drive 3 back-to-back valid requests -> 2 accepted, in_ready=0, first word stable; raise out_ready -> 3 words delivered in order, one per cycle.
- Streaming: 100 random requests, out_ready toggled randomly -> outputs match reference encoder model in order; counters sum to 100.
- Reset mid-stream with both stages full -> outputs and counters go to 0 immediately, in_ready=1, next request encodes correctly.
